audio_mix_mac: RTL and testbench
================================

// Module: audio_mix_mac
// PURPOSE
//  Parametrised N-channel stereo audio mixer for the sound subsystem.
//  On each sample strobe: snapshots all channel inputs and gains, then runs one time-multiplexed
//  multiply-accumulate per clock (one channel per cycle) into L/R accumulators.
//  Scales and saturates the result, then presents stereo and mono outputs with a valid pulse.
//  Sits after the per-source filters (FM, PSG, ADPCM), feeding the DAC/output stage.
// PARAMETERS
//  NCH    4   number of input channels (>=1)
//  IW     16  signed input sample width
//  OW     16  signed output sample width
//  GW     8   unsigned per-channel gain width
//  GF     5   gain fractional bits (gain==2**GF is unity)
//  ACCW   IW+GW+$clog2(NCH)+1  accumulator width (localparam, not overridable)
// PORTS
//  clk          in   1        system clock
//  reset        in   1        asynchronous, active-high reset
//  sample_ce    in   1        one-cycle strobe: start a mix of the current inputs
//  ch_in        in   NCH*IW   signed samples, channel k at [k*IW +: IW]
//  ch_en        in   NCH      per-channel enable; disabled channel contributes 0
//  gain_l       in   NCH*GW   left gains, channel k at [k*GW +: GW]
//  gain_r       in   NCH*GW   right gains, same packing
//  clr_flags    in   1        clears clip_l, clip_r, overrun_cnt
//  out_l        out  OW       signed saturated left mix
//  out_r        out  OW       signed saturated right mix
//  out_mono     out  OW       signed (out_l+out_r)>>>1
//  out_valid    out  1        one-cycle pulse when outputs update
//  busy         out  1        high while a mix is in progress
//  clip_l       out  1        sticky: left result saturated
//  clip_r       out  1        sticky: right result saturated
//  overrun_cnt  out  8        saturating count of sample_ce pulses ignored while busy
// BEHAVIOUR
//  Reset: all outputs and accumulators 0, FSM=IDLE; async assert, sync release.
//  FSM: IDLE -> (sample_ce) ACC -> (ch_idx==NCH-1) SAT -> IDLE.
//  IDLE, sample_ce=1 (cycle t): register ch_in, ch_en, gain_l, gain_r; clear accumulators;
//   ch_idx=0; busy=1 from t+1.
//  ACC (t+1..t+NCH): acc_l += en?in[k]*gain_l[k]:0, same for acc_r; k increments each cycle.
//   Products signed IW x unsigned GW (gain zero-extended), sign-extended to ACCW.
//   Mid-mix changes on inputs have no effect (snapshot).
//  SAT (t+NCH+1): s = acc>>>GF (arithmetic, floor); clamp to [-2**(OW-1), 2**(OW-1)-1].
//   Set clip_x if clamped. Register out_l/out_r; out_mono = (sat_l+sat_r computed at OW+1) >>> 1.
//  Outputs and out_valid=1 visible at cycle t+NCH+2; busy=0 in that same cycle.
//   A new sample_ce is accepted in that cycle.
//  Outputs hold between mixes; out_valid is a single-cycle pulse.
//  sample_ce while busy: ignored, overrun_cnt+1 (saturates at 255).
//  clr_flags and a new clip/overrun in the same cycle: the set wins (flag=1, cnt=1).
//  Reset mid-mix: abort, no out_valid, all outputs 0.
//  All-channels-disabled mix: outputs 0, out_valid still pulses.
// TESTING
//  1 reset asserted -> all outputs 0, busy=0; reset released -> still idle, no out_valid.
//  2 NCH=4, ch0=1000, gain_l0=32, gain_r0=16, ch1..3 en=0, sample_ce @t
//    -> at t+6: out_l=1000, out_r=500, out_mono=750, out_valid one cycle.
//  3 all ch=32767, gains 255 -> out_l=out_r=32767, clip_l=clip_r=1;
//    all ch=-32768 -> out=-32768; clr_flags -> flags 0.
//  4 ch0=-3 gain 1 -> (-3)>>>5 = -1; ch0=100 gain 32, ch1=-100 gain 32 -> out=0, no clip.
//  5 sample_ce @t and @t+2 -> one mix only, overrun_cnt=1; 300 such pulses -> overrun_cnt=255.
//  6 reset @t+3 of a mix -> no out_valid, outputs 0;
//    clr_flags coincident with new clip -> clip stays 1.

Source files
------------

// File: rtl/audio_mix_mac.sv
// N-channel stereo audio mixer: snapshots inputs on sample_ce, runs one multiply-accumulate
// per channel per clock into L/R accumulators, then scales, saturates and presents the mix.
module audio_mix_mac #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = 16,
    parameter int unsigned OW  = 16,
    parameter int unsigned GW  = 8,
    parameter int unsigned GF  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_ce,
    input  logic [NCH*IW-1:0]     ch_in,
    input  logic [NCH-1:0]        ch_en,
    input  logic [NCH*GW-1:0]     gain_l,
    input  logic [NCH*GW-1:0]     gain_r,
    input  logic                  clr_flags,
    output logic signed [OW-1:0]  out_l,
    output logic signed [OW-1:0]  out_r,
    output logic signed [OW-1:0]  out_mono,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  clip_l,
    output logic                  clip_r,
    output logic [7:0]            overrun_cnt
);

    localparam int unsigned ACCW = IW + GW + $clog2(NCH) + 1;
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW   = IW + GW + 1;
    localparam int unsigned OW1  = OW + 1;

    localparam logic signed [ACCW-1:0] ACC_MAX = ACCW'({1'b0, {(OW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [OW-1:0]   OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0]   OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

    state_t                  state;
    logic [CW-1:0]           ch_idx;
    logic [NCH*IW-1:0]       in_q;
    logic [NCH-1:0]          en_q;
    logic [NCH*GW-1:0]       gl_q;
    logic [NCH*GW-1:0]       gr_q;
    logic signed [ACCW-1:0]  acc_l;
    logic signed [ACCW-1:0]  acc_r;

    logic signed [IW-1:0]    cur_in;
    logic [GW-1:0]           cur_gl;
    logic [GW-1:0]           cur_gr;
    logic                    cur_en;
    logic signed [PW-1:0]    prod_l;
    logic signed [PW-1:0]    prod_r;
    logic signed [ACCW-1:0]  term_l;
    logic signed [ACCW-1:0]  term_r;
    logic signed [ACCW-1:0]  shr_l;
    logic signed [ACCW-1:0]  shr_r;
    logic                    clamp_l;
    logic                    clamp_r;
    logic signed [OW-1:0]    sat_l;
    logic signed [OW-1:0]    sat_r;

    // Current channel product (gain zero-extended, so it is always non-negative)
    always_comb begin
        cur_in = in_q[32'(ch_idx)*IW +: IW];
        cur_gl = gl_q[32'(ch_idx)*GW +: GW];
        cur_gr = gr_q[32'(ch_idx)*GW +: GW];
        cur_en = en_q[ch_idx];
        prod_l = PW'(cur_in) * PW'($signed({1'b0, cur_gl}));
        prod_r = PW'(cur_in) * PW'($signed({1'b0, cur_gr}));
        term_l = cur_en ? ACCW'(prod_l) : '0;
        term_r = cur_en ? ACCW'(prod_r) : '0;
    end

    // Scale by gain fraction (floor) and clamp to the output range
    always_comb begin
        shr_l   = acc_l >>> GF;
        shr_r   = acc_r >>> GF;
        clamp_l = (shr_l > ACC_MAX) || (shr_l < ACC_MIN);
        clamp_r = (shr_r > ACC_MAX) || (shr_r < ACC_MIN);
        sat_l   = clamp_l ? (shr_l[ACCW-1] ? OUT_MIN : OUT_MAX) : OW'(shr_l);
        sat_r   = clamp_r ? (shr_r[ACCW-1] ? OUT_MIN : OUT_MAX) : OW'(shr_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ch_idx      <= '0;
            in_q        <= '0;
            en_q        <= '0;
            gl_q        <= '0;
            gr_q        <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
            out_l       <= '0;
            out_r       <= '0;
            out_mono    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            clip_l      <= 1'b0;
            clip_r      <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_ce) begin
                        in_q   <= ch_in;
                        en_q   <= ch_en;
                        gl_q   <= gain_l;
                        gr_q   <= gain_r;
                        acc_l  <= '0;
                        acc_r  <= '0;
                        ch_idx <= '0;
                        busy   <= 1'b1;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    acc_l  <= acc_l + term_l;
                    acc_r  <= acc_r + term_r;
                    ch_idx <= ch_idx + CW'(1);
                    if (ch_idx == CW'(NCH - 1)) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    out_l     <= sat_l;
                    out_r     <= sat_r;
                    out_mono  <= OW'((OW1'(sat_l) + OW1'(sat_r)) >>> 1);
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Sticky flags: a new event in the same cycle as clr_flags wins
            if (state == SAT && clamp_l) begin
                clip_l <= 1'b1;
            end else if (clr_flags) begin
                clip_l <= 1'b0;
            end
            if (state == SAT && clamp_r) begin
                clip_r <= 1'b1;
            end else if (clr_flags) begin
                clip_r <= 1'b0;
            end
            if (sample_ce && busy) begin
                if (clr_flags) begin
                    overrun_cnt <= 8'd1;
                end else if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (clr_flags) begin
                overrun_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_audio_mix_mac.sv
// Randomised self-checking bench for audio_mix_mac against an arithmetic mix model.
module tb_audio_mix_mac;

    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int GW  = 8;
    localparam int GF  = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sample_ce;
    logic [NCH*IW-1:0]     ch_in;
    logic [NCH-1:0]        ch_en;
    logic [NCH*GW-1:0]     gain_l;
    logic [NCH*GW-1:0]     gain_r;
    logic                  clr_flags;
    logic signed [OW-1:0]  out_l;
    logic signed [OW-1:0]  out_r;
    logic signed [OW-1:0]  out_mono;
    logic                  out_valid;
    logic                  busy;
    logic                  clip_l;
    logic                  clip_r;
    logic [7:0]            overrun_cnt;

    audio_mix_mac #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .GF(GF)) dut (
        .clk(clk), .reset(reset), .sample_ce(sample_ce), .ch_in(ch_in), .ch_en(ch_en),
        .gain_l(gain_l), .gain_r(gain_r), .clr_flags(clr_flags), .out_l(out_l),
        .out_r(out_r), .out_mono(out_mono), .out_valid(out_valid), .busy(busy),
        .clip_l(clip_l), .clip_r(clip_r), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int in_v[NCH];
    int en_v[NCH];
    int gl_v[NCH];
    int gr_v[NCH];

    bit e_clip_l, e_clip_r;
    int e_ovr;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < NCH; k++) begin
            ch_in[k*IW +: IW]  = IW'(in_v[k]);
            ch_en[k]           = en_v[k][0];
            gain_l[k*GW +: GW] = GW'(gl_v[k]);
            gain_r[k*GW +: GW] = GW'(gr_v[k]);
        end
    endtask

    // Junk on the inputs while a mix runs; the snapshot must ignore it
    task automatic scramble();
        ch_in  = (NCH*IW)'({$urandom(), $urandom()});
        ch_en  = NCH'($urandom());
        gain_l = (NCH*GW)'($urandom());
        gain_r = (NCH*GW)'($urandom());
    endtask

    function automatic longint clamp(input longint v, output bit c);
        longint mx = (64'sd1 <<< (OW - 1)) - 1;
        longint mn = -(64'sd1 <<< (OW - 1));
        c = (v > mx) || (v < mn);
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    function automatic void mix_ref(output longint l, output longint r, output longint m,
                                    output bit cl, output bit cr);
        longint al = 0;
        longint ar = 0;
        for (int k = 0; k < NCH; k++) begin
            if (en_v[k] != 0) begin
                al += longint'(in_v[k]) * longint'(gl_v[k]);
                ar += longint'(in_v[k]) * longint'(gr_v[k]);
            end
        end
        l = clamp(al >>> GF, cl);
        r = clamp(ar >>> GF, cr);
        m = (l + r) >>> 1;
    endfunction

    task automatic rand_inputs(input bit loud);
        for (int k = 0; k < NCH; k++) begin
            in_v[k] = int'($urandom_range(0, 65535)) - 32768;
            en_v[k] = int'($urandom_range(0, 1));
            gl_v[k] = (loud || $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                         : int'($urandom_range(0, 48));
            gr_v[k] = (loud || $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                         : int'($urandom_range(0, 48));
        end
    endtask

    // One mix; extra_at/clr_at = cycle after the strobe to pulse sample_ce/clr_flags (0 = never)
    task automatic do_mix(input int extra_at, input int clr_at);
        longint el, er, em;
        bit cl, cr, done;
        int lat;
        mix_ref(el, er, em, cl, cr);
        @(negedge clk);
        apply_inputs();
        sample_ce = 1'b1;
        done = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (out_valid) begin
                done = 1'b1;
                lat  = k;
                sample_ce = 1'b0;
                clr_flags = 1'b0;
            end else begin
                if (k == 1) chk("busy_in_mix", busy, 1);
                sample_ce = (k == extra_at);
                clr_flags = (k == clr_at);
                if (k == clr_at) begin
                    e_clip_l = 1'b0;
                    e_clip_r = 1'b0;
                    e_ovr    = 0;
                end
                if (k == extra_at) e_ovr = (k == clr_at) ? 1 : ((e_ovr < 255) ? e_ovr + 1 : 255);
                scramble();
            end
        end
        e_clip_l |= cl;
        e_clip_r |= cr;
        chk("latency", lat, NCH + 2);
        chk("busy_at_valid", busy, 0);
        chk("out_l", out_l, el);
        chk("out_r", out_r, er);
        chk("out_mono", out_mono, em);
        chk("clip_l", clip_l, e_clip_l);
        chk("clip_r", clip_r, e_clip_r);
        chk("overrun_cnt", overrun_cnt, e_ovr);
        @(negedge clk);
        chk("valid_pulse", out_valid, 0);
        chk("hold_l", out_l, el);
        chk("hold_r", out_r, er);
    endtask

    task automatic clr_idle();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        e_clip_l = 1'b0;
        e_clip_r = 1'b0;
        e_ovr    = 0;
        chk("clr_clip_l", clip_l, 0);
        chk("clr_clip_r", clip_r, 0);
        chk("clr_ovr", overrun_cnt, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_l"}, out_l, 0);
        chk({tag, "_r"}, out_r, 0);
        chk({tag, "_mono"}, out_mono, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_clip"}, {clip_l, clip_r}, 0);
        chk({tag, "_ovr"}, overrun_cnt, 0);
    endtask

    task automatic set_all(input int v, input int e, input int g);
        for (int k = 0; k < NCH; k++) begin
            in_v[k] = v;
            en_v[k] = e;
            gl_v[k] = g;
            gr_v[k] = g;
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_ce = 1'b0;
        clr_flags = 1'b0;
        ch_in = '0;
        ch_en = '0;
        gain_l = '0;
        gain_r = '0;
        e_clip_l = 1'b0;
        e_clip_r = 1'b0;
        e_ovr = 0;

        // Reset state and quiet release
        repeat (2) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
        end
        chk("post_rst_busy", busy, 0);

        // Single channel, unity left, half right
        set_all(0, 0, 77);
        in_v[0] = 1000; en_v[0] = 1; gl_v[0] = 32; gr_v[0] = 16;
        do_mix(0, 0);
        chk("t2_l_abs", out_l, 1000);
        chk("t2_r_abs", out_r, 500);
        chk("t2_mono_abs", out_mono, 750);

        // Saturation both ways, then clear
        set_all(32767, 1, 255);
        do_mix(0, 0);
        chk("t3_pos_abs", out_l, 32767);
        set_all(-32768, 1, 255);
        do_mix(0, 0);
        chk("t3_neg_abs", out_r, -32768);
        clr_idle();

        // Floor rounding and cancellation
        set_all(0, 0, 200);
        in_v[0] = -3; en_v[0] = 1; gl_v[0] = 1; gr_v[0] = 1;
        do_mix(0, 0);
        chk("t4_floor_abs", out_l, -1);
        set_all(0, 0, 0);
        in_v[0] = 100; en_v[0] = 1; gl_v[0] = 32; gr_v[0] = 32;
        in_v[1] = -100; en_v[1] = 1; gl_v[1] = 32; gr_v[1] = 32;
        do_mix(0, 0);

        // All channels disabled
        set_all(12345, 0, 255);
        do_mix(0, 0);

        // Overrun counting and saturation
        set_all(500, 1, 10);
        do_mix(2, 0);
        chk("t5_ovr1_abs", overrun_cnt, 1);
        for (int i = 0; i < 300; i++) begin
            rand_inputs(1'b0);
            do_mix(2, 0);
        end
        chk("t5_ovr_sat_abs", overrun_cnt, 255);

        // clr_flags coincident with new clip and new overrun: set wins
        clr_idle();
        set_all(32767, 1, 255);
        do_mix(NCH + 1, NCH + 1);
        chk("t6_clip_wins", clip_l, 1);
        chk("t6_ovr_wins", overrun_cnt, 1);

        // Reset in the middle of a mix
        @(negedge clk);
        apply_inputs();
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        e_clip_l = 1'b0;
        e_clip_r = 1'b0;
        e_ovr = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", out_valid, 0);
        end

        // Randomised mixes with stray strobes and clears
        for (int i = 0; i < 60; i++) begin
            rand_inputs(i % 5 == 0);
            do_mix(int'($urandom_range(0, NCH + 1)), int'($urandom_range(0, NCH + 1)));
            if (i % 7 == 0) clr_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
